// File: rtl/pipeline_controller.sv
// Stage-enable sequencer for the fetch/decode/execute/memory pipe: pipe fill, LDR-use bubble,
// taken-branch flush, and global freeze on mem_busy. Optional perf counters: PIPE_PERF_COUNTERS_EN.
module pipeline_controller #(
  parameter int FILL_DEPTH   = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 decoder_ready,
  input  logic                 stall_for_ldr,
  input  logic                 branch_taken,
  input  logic                 mem_busy,
  output logic                 fetch_enable,
  output logic                 decoder_enable,
  output logic                 executor_enable,
  output logic                 memory_enable,
  output logic                 executor_bubble,
  output logic                 flush,
`ifdef PIPE_PERF_COUNTERS_EN
  output logic [CNT_WIDTH-1:0] perf_ldr_stalls,
  output logic [CNT_WIDTH-1:0] perf_flushes,
  output logic [CNT_WIDTH-1:0] perf_mem_wait,
`endif
  output logic [1:0]           dbg_state
);

  localparam int FILL_W  = (FILL_DEPTH   > 1) ? $clog2(FILL_DEPTH + 1)   : 1;
  localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(FILL_DEPTH - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);

  if (FILL_DEPTH < 1)   begin : g_bad_fill   $error("FILL_DEPTH must be >= 1");   end
  if (FLUSH_CYCLES < 1) begin : g_bad_flush  $error("FLUSH_CYCLES must be >= 1"); end
  if (CNT_WIDTH < 1)    begin : g_bad_cnt    $error("CNT_WIDTH must be >= 1");    end

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    RUN       = 2'd1,
    LDR_STALL = 2'd2,
    FLUSH     = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [FILL_W-1:0]    fill_cnt_q, fill_cnt_d;
  logic [FLUSH_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic                 ldr_served_q, ldr_served_d;

  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= FILL;
      fill_cnt_q   <= '0;
      flush_cnt_q  <= '0;
      ldr_served_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_cnt_q   <= fill_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      ldr_served_q <= ldr_served_d;
    end
  end

  // Outputs are combinational so a freeze or flush takes effect in the cycle its input arrives.
  always_comb begin
    state_d         = state_q;
    fill_cnt_d      = fill_cnt_q;
    flush_cnt_d     = flush_cnt_q;
    ldr_served_d    = ldr_served_q;
    fetch_enable    = 1'b0;
    decoder_enable  = 1'b0;
    executor_enable = 1'b0;
    memory_enable   = 1'b0;
    executor_bubble = 1'b0;
    flush           = 1'b0;
    if (nreset && !mem_busy) begin
      case (state_q)
        FILL: begin
          fetch_enable   = 1'b1;
          decoder_enable = (fill_cnt_q != '0);
          if (fill_cnt_q >= FILL_LAST) state_d = RUN;
          else                         fill_cnt_d = fill_cnt_q + 1'b1;
        end
        RUN: begin
          fetch_enable    = 1'b1;
          decoder_enable  = 1'b1;
          executor_enable = 1'b1;
          memory_enable   = 1'b1;
          if (branch_taken) begin
            flush           = 1'b1;
            decoder_enable  = 1'b0;
            executor_bubble = 1'b1;
            flush_cnt_d     = FLUSH_LAST;
            state_d         = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
          end else if (stall_for_ldr && decoder_ready && !ldr_served_q) begin
            fetch_enable    = 1'b0;
            decoder_enable  = 1'b0;
            executor_bubble = 1'b1;
            state_d         = LDR_STALL;
          end else begin
            ldr_served_d = 1'b0;
          end
        end
        LDR_STALL: begin
          fetch_enable    = 1'b1;
          decoder_enable  = 1'b1;
          executor_enable = 1'b1;
          memory_enable   = 1'b1;
          ldr_served_d    = 1'b1;
          state_d         = RUN;
        end
        FLUSH: begin
          fetch_enable    = 1'b1;
          decoder_enable  = 1'b1;
          executor_enable = 1'b1;
          memory_enable   = 1'b1;
          executor_bubble = 1'b1;
          if (flush_cnt_q == '0) state_d = RUN;
          else                   flush_cnt_d = flush_cnt_q - 1'b1;
        end
        default: state_d = FILL;
      endcase
    end
  end

`ifdef PIPE_PERF_COUNTERS_EN
  logic                 ldr_evt, br_evt;
  logic [CNT_WIDTH-1:0] ldr_cnt_q, br_cnt_q, mw_cnt_q;

  assign ldr_evt = (state_q == RUN) && (state_d == LDR_STALL);
  assign br_evt  = (state_q == RUN) && flush;

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ldr_cnt_q <= '0;
      br_cnt_q  <= '0;
      mw_cnt_q  <= '0;
    end else begin
      if (ldr_evt && ldr_cnt_q != '1) ldr_cnt_q <= ldr_cnt_q + 1'b1;
      if (br_evt && br_cnt_q != '1)   br_cnt_q  <= br_cnt_q + 1'b1;
      if (mem_busy && mw_cnt_q != '1) mw_cnt_q  <= mw_cnt_q + 1'b1;
    end
  end

  assign perf_ldr_stalls = ldr_cnt_q;
  assign perf_flushes    = br_cnt_q;
  assign perf_mem_wait   = mw_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_controller.sv
// Bench for pipeline_controller: reference model pushes expected outputs per cycle, compared after settle.
module tb_pipeline_controller;

  localparam int FILL_DEPTH   = 2;
  localparam int FLUSH_CYCLES = 2;
`ifdef PIPE_PERF_COUNTERS_EN
  localparam int CNT_WIDTH    = 2;
`else
  localparam int CNT_WIDTH    = 16;
`endif
  localparam int MAXC = (1 << CNT_WIDTH) - 1;

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_LDR   = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic clk, nreset, decoder_ready, stall_for_ldr, branch_taken, mem_busy;
  logic fetch_enable, decoder_enable, executor_enable, memory_enable, executor_bubble, flush;
  logic [1:0] dbg_state;
`ifdef PIPE_PERF_COUNTERS_EN
  logic [CNT_WIDTH-1:0] perf_ldr_stalls, perf_flushes, perf_mem_wait;
`endif

  pipeline_controller #(
    .FILL_DEPTH(FILL_DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .nreset(nreset),
    .decoder_ready(decoder_ready), .stall_for_ldr(stall_for_ldr),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .fetch_enable(fetch_enable), .decoder_enable(decoder_enable),
    .executor_enable(executor_enable), .memory_enable(memory_enable),
    .executor_bubble(executor_bubble), .flush(flush),
`ifdef PIPE_PERF_COUNTERS_EN
    .perf_ldr_stalls(perf_ldr_stalls), .perf_flushes(perf_flushes), .perf_mem_wait(perf_mem_wait),
`endif
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [1:0] m_state;
  int m_fill, m_flush, m_perf_ldr, m_perf_fl, m_perf_mw;
  logic m_served;

  task automatic model_reset();
    m_state = S_FILL; m_fill = 0; m_flush = 0; m_served = 1'b0;
    m_perf_ldr = 0; m_perf_fl = 0; m_perf_mw = 0;
  endtask

  // One clock cycle: drive, predict {fetch,dec,exe,mem,bubble,flush,state}, compare, advance model.
  task automatic step(input string tag, input logic rn, input logic dr, input logic st,
                      input logic br, input logic mb);
    logic [5:0] e;
    logic [7:0] got;
    @(negedge clk);
    nreset = rn; decoder_ready = dr; stall_for_ldr = st; branch_taken = br; mem_busy = mb;
    if (!rn) model_reset();
    e = 6'b000000;
    if (rn && !mb) begin
      case (m_state)
        S_FILL:  e = {1'b1, (m_fill >= 1), 4'b0000};
        S_RUN:   if (br)                          e = 6'b101111;
                 else if (st && dr && !m_served)  e = 6'b001110;
                 else                             e = 6'b111100;
        S_LDR:   e = 6'b111100;
        default: e = 6'b111110;
      endcase
    end
    exp_q.push_back({e, m_state});
    #2;
    got = {fetch_enable, decoder_enable, executor_enable, memory_enable,
           executor_bubble, flush, dbg_state};
    check(tag, 32'(got), 32'(exp_q.pop_front()));
`ifdef PIPE_PERF_COUNTERS_EN
    check({tag, "_perf_ldr"}, 32'(perf_ldr_stalls), 32'(m_perf_ldr));
    check({tag, "_perf_fl"},  32'(perf_flushes),    32'(m_perf_fl));
    check({tag, "_perf_mw"},  32'(perf_mem_wait),   32'(m_perf_mw));
`endif
    @(posedge clk);
    if (rn) begin
      if (mb) begin
        if (m_perf_mw < MAXC) m_perf_mw++;
      end else begin
        case (m_state)
          S_FILL: if (m_fill >= FILL_DEPTH - 1) m_state = S_RUN; else m_fill++;
          S_RUN: begin
            if (br) begin
              m_flush = FLUSH_CYCLES - 1;
              m_state = (FLUSH_CYCLES == 1) ? S_RUN : S_FLUSH;
              if (m_perf_fl < MAXC) m_perf_fl++;
            end else if (st && dr && !m_served) begin
              m_state = S_LDR;
              if (m_perf_ldr < MAXC) m_perf_ldr++;
            end else begin
              m_served = 1'b0;
            end
          end
          S_LDR: begin m_served = 1'b1; m_state = S_RUN; end
          default: if (m_flush == 0) m_state = S_RUN; else m_flush--;
        endcase
      end
    end
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    nreset = 1'b0; decoder_ready = 1'b0; stall_for_ldr = 1'b0;
    branch_taken = 1'b0; mem_busy = 1'b0;
    model_reset();

    // Reset holds every output low whatever the inputs
    step("reset", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step("reset", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

    // Pipe fill: fetch at cycle 0, decoder at 1, all from 2
    step("fill0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("fill1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle("run", 2);

    // LDR hazard held 2 cycles, then held 3 cycles: one bubble each
    step("ldr_a", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("ldr_b", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle("ldr_after", 2);
    for (int i = 0; i < 3; i++) step("ldr_hold", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle("run", 1);

    // Taken branch: flush pulse then two bubbles
    step("branch", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle("flush", 3);

    // Branch then mem_busy 3 cycles in first FLUSH cycle, wrong-path inputs ignored
    step("branch2", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("mem_frz", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step("flush_ign", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    idle("flush_end", 3);

    // Branch and LDR hazard together: flush path only
    step("br_ldr", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step("br_ldr_f", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("br_ldr_f", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("br_ldr_r", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle("run", 2);

    // mem_busy 5 cycles in RUN (saturates a 2-bit wait counter)
    for (int i = 0; i < 5; i++) step("mem_run", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    idle("run", 1);

    // Reset in the middle of a flush
    step("branch3", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step("mid_rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("refill0", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step("refill1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle("run", 2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(0, 99) >= 2),
           ($urandom_range(0, 99) < 70),
           ($urandom_range(0, 99) < 30),
           ($urandom_range(0, 99) < 12),
           ($urandom_range(0, 99) < 15));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
